// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Brief    : Shared defaults, typedefs and FSM state encoding for the APB slave.
// Revision : 1.0
// ============================================================================
package apb_pkg;

    localparam int c_APB_ADDR_WIDTH = 13;
    localparam int c_APB_DATA_WIDTH = 32;
    localparam int c_MEM_BYTES      = 256;
    localparam int c_WAIT_STATES    = 1;
    localparam int c_WAIT_CNT_W     = 4;

    typedef logic [c_APB_ADDR_WIDTH-1:0] apb_addr_t;
    typedef logic [c_APB_DATA_WIDTH-1:0] apb_data_t;
    typedef logic [c_WAIT_CNT_W-1:0]     wait_cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACCESS = 2'd3
    } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_slave_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_mem_array
// Brief    : Word-organised byte-writable storage with async read and reset clear.
// Revision : 1.0
// ============================================================================
module apb_slave_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 64,
    parameter int IDX_W      = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_we,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [IDX_W-1:0]        i_idx,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int c_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [WORDS];

    // Strobe bit b guards bits [8b+:8], i.e. memory byte (word base + c_BYTES-1-b).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < WORDS; w++) begin
                r_mem[w] <= '0;
            end
        end else if (i_we) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule
`default_nettype wire

// File: rtl/apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_mem
// Brief    : APB slave with programmable wait states backed by a byte-lane memory.
// Revision : 1.0
// ============================================================================
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = c_APB_ADDR_WIDTH,
    parameter int APB_DATA_WIDTH = c_APB_DATA_WIDTH,
    parameter int MEM_BYTES      = c_MEM_BYTES,
    parameter int WAIT_STATES    = c_WAIT_STATES
) (
    input  logic                        PCLK,
    input  logic                        PRESET,
    input  logic                        PSEL,
    input  logic                        PENABLE,
    input  logic                        PWRITE,
    input  logic [APB_ADDR_WIDTH-1:0]   PADDR,
    input  logic [APB_DATA_WIDTH-1:0]   PWDATA,
    input  logic [APB_DATA_WIDTH/8-1:0] PSTRB,
    output logic                        PREADY,
    output logic [APB_DATA_WIDTH-1:0]   PRDATA,
    output logic                        PSLVERR
);

    localparam int c_BYTES = APB_DATA_WIDTH / 8;
    localparam int c_LSB   = $clog2(c_BYTES);
    localparam int c_WORDS = MEM_BYTES / c_BYTES;
    localparam int c_IDX_W = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
    localparam logic [APB_ADDR_WIDTH:0]   c_MEM_LIMIT  = (APB_ADDR_WIDTH+1)'(MEM_BYTES);
    localparam logic [APB_ADDR_WIDTH-1:0] c_ALIGN_MASK = APB_ADDR_WIDTH'(c_BYTES - 1);
    localparam wait_cnt_t                 c_WAIT       = wait_cnt_t'(WAIT_STATES);

    apb_state_e                  r_state;
    apb_state_e                  w_state;
    wait_cnt_t                   r_cnt;
    logic [APB_ADDR_WIDTH-1:0]   r_addr;
    logic                        r_write;
    logic [APB_DATA_WIDTH-1:0]   r_wdata;
    logic [c_BYTES-1:0]          r_strb;
    logic                        w_err;
    logic                        w_mem_we;
    logic [APB_DATA_WIDTH-1:0]   w_rdata;

    // The setup phase is decoded straight from the bus so a zero-wait
    // transfer completes in the cycle right after its setup phase.
    always_comb begin
        w_state = r_state;
        if (r_state == ST_IDLE && PSEL && !PENABLE) begin
            w_state = ST_SETUP;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
        end else begin
            case (w_state)
                ST_SETUP: begin
                    r_addr  <= PADDR;
                    r_write <= PWRITE;
                    r_wdata <= PWDATA;
                    r_strb  <= PSTRB;
                    r_cnt   <= c_WAIT;
                    r_state <= (c_WAIT != '0) ? ST_WAIT : ST_ACCESS;
                end
                ST_WAIT: begin
                    if (!PSEL) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt <= wait_cnt_t'(1)) begin
                            r_state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_err    = ({1'b0, r_addr} >= c_MEM_LIMIT) || (|(r_addr & c_ALIGN_MASK));
    assign w_mem_we = (r_state == ST_ACCESS) && r_write && !w_err;

    apb_slave_mem_array #(
        .DATA_WIDTH (APB_DATA_WIDTH),
        .WORDS      (c_WORDS),
        .IDX_W      (c_IDX_W)
    ) u_mem (
        .clk     (PCLK),
        .rst     (PRESET),
        .i_we    (w_mem_we),
        .i_be    (r_strb),
        .i_idx   (r_addr[c_LSB +: c_IDX_W]),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    assign PREADY  = (r_state == ST_ACCESS);
    assign PSLVERR = PREADY && w_err;
    assign PRDATA  = (PREADY && !r_write && !w_err) ? w_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave_mem
// Brief    : Directed self-checking bench with a byte-array reference model.
// Revision : 1.0
// ============================================================================
module tb_apb_slave_mem;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int MB = 256;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          psel1, psel0, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic          rdy1, rdy0, err1, err0;
    logic [DW-1:0] rd1, rd0;

    always #5 PCLK = ~PCLK;

    apb_slave_mem #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .MEM_BYTES(MB), .WAIT_STATES(1)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(rdy1), .PRDATA(rd1), .PSLVERR(err1)
    );

    apb_slave_mem #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .MEM_BYTES(MB), .WAIT_STATES(0)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(rdy0), .PRDATA(rd0), .PSLVERR(err0)
    );

    // Index 0 models the one-wait-state instance, index 1 the zero-wait one.
    logic [7:0]    mm     [2][MB];
    logic          exp_rdy[2];
    logic [DW-1:0] exp_rd [2];
    logic          exp_err[2];
    int            n_cmp  = 0;
    int            n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic m_err(input logic [AW-1:0] a);
        return (int'(a) >= MB) || (a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] m_read(input int u, input logic [AW-1:0] a);
        return {mm[u][a], mm[u][a+1], mm[u][a+2], mm[u][a+3]};
    endfunction

    function automatic logic dut_rdy(input int u);
        return (u == 0) ? rdy1 : rdy0;
    endfunction

    function automatic logic [31:0] dut_rd(input int u);
        return (u == 0) ? rd1 : rd0;
    endfunction

    function automatic logic dut_err(input int u);
        return (u == 0) ? err1 : err0;
    endfunction

    task automatic set_sel(input int u, input logic v);
        if (u == 0) psel1 = v;
        else        psel0 = v;
    endtask

    always @(negedge PCLK) begin
        chk("pready_w1", 32'(rdy1), 32'(exp_rdy[0]));
        chk("prdata_w1", rd1, exp_rd[0]);
        if (exp_rdy[0]) chk("pslverr_w1", 32'(err1), 32'(exp_err[0]));
        chk("pready_w0", 32'(rdy0), 32'(exp_rdy[1]));
        chk("prdata_w0", rd0, exp_rd[1]);
        if (exp_rdy[1]) chk("pslverr_w0", 32'(err0), 32'(exp_err[1]));
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic xfer(input int u, input logic wr, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output logic er);
        int          ws;
        int          n;
        logic        e;
        logic [31:0] rexp;
        ws   = (u == 0) ? 1 : 0;
        n    = 0;
        e    = m_err(a);
        rexp = (!wr && !e) ? m_read(u, a) : 32'h0;
        set_sel(u, 1'b1);
        penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        exp_rdy[u] = 1'b0; exp_rd[u] = '0; exp_err[u] = 1'b0;
        @(posedge PCLK); #1;
        penable = 1'b1;
        if (ws > 0) begin
            pwrite = ~wr; paddr = AW'($urandom); pwdata = $urandom; pstrb = SW'($urandom);
        end
        forever begin
            exp_rdy[u] = (n == ws);
            exp_rd[u]  = (n == ws) ? rexp : 32'h0;
            exp_err[u] = (n == ws) ? e : 1'b0;
            @(negedge PCLK);
            if (dut_rdy(u) || n >= 16) break;
            n++;
            @(posedge PCLK); #1;
            if (n == ws) begin
                pwrite = wr; paddr = a; pwdata = d; pstrb = s;
            end
        end
        rd = dut_rd(u);
        er = dut_err(u);
        chk("xfer_wait_cycles", 32'(n), 32'(ws));
        @(posedge PCLK); #1;
        exp_rdy[u] = 1'b0; exp_rd[u] = '0; exp_err[u] = 1'b0;
        if (wr && !e) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) mm[u][a + AW'(3 - i)] = d[8*i +: 8];
            end
        end
        set_sel(u, 1'b0);
        penable = 1'b0;
    endtask

    task automatic clear_model();
        for (int u = 0; u < 2; u++) begin
            for (int b = 0; b < MB; b++) mm[u][b] = 8'h00;
        end
    endtask

    logic [31:0] rd;
    logic        er;
    logic [31:0] vals [64];

    initial begin
        PRESET = 1'b1;
        psel1 = 1'b0; psel0 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        for (int u = 0; u < 2; u++) begin
            exp_rdy[u] = 1'b0; exp_rd[u] = '0; exp_err[u] = 1'b0;
        end
        clear_model();
        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_pready", 32'(rdy1), 32'h0);
        chk("rst_prdata", rd1, 32'h0);
        chk("rst_pslverr", 32'(err1), 32'h0);
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        // Full-word write and read-back
        xfer(0, 1'b1, 13'h0004, 32'hDEADBEEF, 4'hF, rd, er);
        xfer(0, 1'b0, 13'h0004, 32'h0, 4'hF, rd, er);
        chk("s1_rdata", rd, 32'hDEADBEEF);
        chk("s1_err", 32'(er), 32'h0);

        // Partial strobes onto a zeroed word
        xfer(0, 1'b1, 13'h0008, 32'h11223344, 4'h5, rd, er);
        xfer(0, 1'b0, 13'h0008, 32'h0, 4'hF, rd, er);
        chk("s2_rdata", rd, 32'h00220044);

        // Out-of-range and misaligned accesses
        xfer(0, 1'b0, 13'h0100, 32'h0, 4'hF, rd, er);
        chk("s3_oor_err", 32'(er), 32'h1);
        chk("s3_oor_rdata", rd, 32'h0);
        xfer(0, 1'b0, 13'h0002, 32'h0, 4'hF, rd, er);
        chk("s3_mis_err", 32'(er), 32'h1);
        chk("s3_mis_rdata", rd, 32'h0);
        xfer(0, 1'b1, 13'h0100, 32'hFFFFFFFF, 4'hF, rd, er);
        chk("s3_wr_err", 32'(er), 32'h1);
        xfer(0, 1'b0, 13'h0000, 32'h0, 4'hF, rd, er);
        chk("s3_word0", rd, 32'h0);
        xfer(0, 1'b0, 13'h0004, 32'h0, 4'hF, rd, er);
        chk("s3_word4", rd, 32'hDEADBEEF);

        // PENABLE without a setup phase is ignored
        psel1 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 13'h000C;
        pwdata = 32'h55555555; pstrb = 4'hF;
        repeat (3) begin @(posedge PCLK); #1; end
        psel1 = 1'b0; penable = 1'b0;
        xfer(0, 1'b0, 13'h000C, 32'h0, 4'hF, rd, er);
        chk("noset_rdata", rd, 32'h0);

        // PSEL dropped during the wait cycle aborts the write
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 13'h0020;
        pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
        @(posedge PCLK); #1;
        penable = 1'b1; psel1 = 1'b0;
        @(posedge PCLK); #1;
        penable = 1'b0;
        @(posedge PCLK); #1;
        xfer(0, 1'b0, 13'h0020, 32'h0, 4'hF, rd, er);
        chk("abort_rdata", rd, 32'h0);

        // Zero wait states, back to back
        xfer(1, 1'b1, 13'h00FC, 32'h5A5AC3C3, 4'hF, rd, er);
        xfer(1, 1'b0, 13'h00FC, 32'h0, 4'hF, rd, er);
        chk("s4_rdata", rd, 32'h5A5AC3C3);
        chk("s4_err", 32'(er), 32'h0);

        // Reset during the wait cycle of a write
        xfer(0, 1'b1, 13'h0010, 32'h12345678, 4'hF, rd, er);
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 13'h0010;
        pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(posedge PCLK); #1;
        penable = 1'b1;
        #2;
        PRESET = 1'b1;
        clear_model();
        #1;
        chk("s5_pready_rst", 32'(rdy1), 32'h0);
        chk("s5_prdata_rst", rd1, 32'h0);
        psel1 = 1'b0; penable = 1'b0;
        repeat (2) begin @(posedge PCLK); #1; end
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        xfer(0, 1'b0, 13'h0010, 32'h0, 4'hF, rd, er);
        chk("s5_rdata", rd, 32'h0);
        xfer(0, 1'b0, 13'h0004, 32'h0, 4'hF, rd, er);
        chk("s5_cleared", rd, 32'h0);

        // Fill every word, then read everything back
        for (int w = 0; w < 64; w++) begin
            vals[w] = $urandom;
            xfer(0, 1'b1, AW'(w * 4), vals[w], 4'hF, rd, er);
            chk("s6_wr_err", 32'(er), 32'h0);
        end
        for (int w = 0; w < 64; w++) begin
            xfer(0, 1'b0, AW'(w * 4), 32'h0, 4'hF, rd, er);
            chk("s6_word", rd, vals[w]);
            chk("s6_rd_err", 32'(er), 32'h0);
        end

        repeat (2) @(posedge PCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
